axi_lite_mem_arbiter: RTL and testbench

- Shares the single AXI4-Lite main-memory port between NUM_REQ cache instances, e.g. an I-cache and a D-cache, each built as cache_top.
- Sits between the caches' AXI master signals and main memory.
- Grants one requester at a time with round-robin fairness and holds the grant for the whole transaction: AR+R for reads, AW+W+B for writes.
- Forwards handshakes combinationally for the granted requester only.

---
 rtl/axi_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/axi_lite_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_axi_lite_mem_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and defaults for the AXI4-Lite memory arbiter.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WRITE   = 3'd3,
    WR_RESP = 3'd4
  } arb_state_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request above last_grant, wrapping.
// Zero latency; no backpressure (pure function of req and last_grant).
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  int unsigned idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!any_req && req[idx]) begin
        winner  = IDX_W'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Round-robin share of one AXI4-Lite memory port; grant held for a whole transaction.
// 1-cycle arbitration latency, then handshakes forwarded combinationally; memory stalls hold state.
module axi_lite_mem_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [NUM_REQ-1:0]        s_ar_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] s_ar_address,
  output logic [NUM_REQ-1:0]        s_ar_ready,
  output logic [NUM_REQ-1:0]        s_r_valid,
  output logic [DATA_W-1:0]         s_r_data,
  input  logic [NUM_REQ-1:0]        s_r_ready,
  input  logic [NUM_REQ-1:0]        s_aw_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] s_aw_address,
  output logic [NUM_REQ-1:0]        s_aw_ready,
  input  logic [NUM_REQ-1:0]        s_w_valid,
  input  logic [NUM_REQ*DATA_W-1:0] s_w_data,
  output logic [NUM_REQ-1:0]        s_w_ready,
  output logic [NUM_REQ-1:0]        s_b_valid,
  output logic                      s_b_response,
  input  logic [NUM_REQ-1:0]        s_b_ready,

  output logic                      m_ar_valid,
  input  logic                      m_ar_ready,
  output logic [ADDR_W-1:0]         m_ar_address,
  input  logic                      m_r_valid,
  output logic                      m_r_ready,
  input  logic [DATA_W-1:0]         m_r_data,
  output logic                      m_aw_valid,
  input  logic                      m_aw_ready,
  output logic [ADDR_W-1:0]         m_aw_address,
  output logic                      m_w_valid,
  input  logic                      m_w_ready,
  output logic [DATA_W-1:0]         m_w_data,
  input  logic                      m_b_valid,
  output logic                      m_b_ready,
  input  logic                      m_b_response
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, last_grant_q, winner;
  logic               any_req;
  logic               aw_done_q, aw_done_d, w_done_q, w_done_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req        (s_ar_valid | s_aw_valid),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (state_q == IDLE && any_req) begin
        grant_q      <= winner;
        last_grant_q <= winner;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    m_ar_valid   = 1'b0;
    m_ar_address = '0;
    m_r_ready    = 1'b0;
    m_aw_valid   = 1'b0;
    m_aw_address = '0;
    m_w_valid    = 1'b0;
    m_w_data     = '0;
    m_b_ready    = 1'b0;
    s_ar_ready   = '0;
    s_r_valid    = '0;
    s_r_data     = '0;
    s_aw_ready   = '0;
    s_w_ready    = '0;
    s_b_valid    = '0;
    s_b_response = 1'b0;

    case (state_q)
      IDLE: begin
        // A writeback must reach memory before the same cache's refill read.
        if (any_req) state_d = s_aw_valid[winner] ? WRITE : RD_ADDR;
      end
      RD_ADDR: begin
        m_ar_valid          = s_ar_valid[grant_q];
        m_ar_address        = s_ar_address[grant_q*ADDR_W +: ADDR_W];
        s_ar_ready[grant_q] = m_ar_ready;
        if (m_ar_valid && m_ar_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        s_r_valid[grant_q] = m_r_valid;
        m_r_ready          = s_r_ready[grant_q];
        s_r_data           = m_r_data;
        if (m_r_valid && m_r_ready) state_d = IDLE;
      end
      WRITE: begin
        // Each channel is masked once its handshake is done so it is not repeated.
        m_aw_valid          = s_aw_valid[grant_q] & ~aw_done_q;
        m_aw_address        = s_aw_address[grant_q*ADDR_W +: ADDR_W];
        s_aw_ready[grant_q] = m_aw_ready & ~aw_done_q;
        m_w_valid           = s_w_valid[grant_q] & ~w_done_q;
        m_w_data            = s_w_data[grant_q*DATA_W +: DATA_W];
        s_w_ready[grant_q]  = m_w_ready & ~w_done_q;
        aw_done_d = aw_done_q | (m_aw_valid & m_aw_ready);
        w_done_d  = w_done_q  | (m_w_valid & m_w_ready);
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: begin
        s_b_valid[grant_q] = m_b_valid;
        m_b_ready          = s_b_ready[grant_q];
        s_b_response       = m_b_response;
        if (m_b_valid && m_b_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Directed bench for axi_lite_mem_arbiter with two requesters; bench drives both sides.
module tb_axi_lite_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic [1:0]  s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
  logic [63:0] s_ar_address, s_aw_address, s_w_data;
  logic [31:0] s_r_data;
  logic        s_b_response;
  logic        m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
  logic        m_b_valid, m_b_ready, m_b_response;
  logic [31:0] m_ar_address, m_aw_address, m_r_data, m_w_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_lite_mem_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_ar_valid(s_ar_valid), .s_ar_address(s_ar_address), .s_ar_ready(s_ar_ready),
    .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_ready(s_r_ready),
    .s_aw_valid(s_aw_valid), .s_aw_address(s_aw_address), .s_aw_ready(s_aw_ready),
    .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_ready(s_w_ready),
    .s_b_valid(s_b_valid), .s_b_response(s_b_response), .s_b_ready(s_b_ready),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_address(m_ar_address),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_address(m_aw_address),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_response(m_b_response)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] hs_bits();
    return {1'b0, m_ar_valid, m_r_ready, m_aw_valid, m_w_valid, m_b_ready,
            s_ar_ready, s_r_valid, s_aw_ready, s_w_ready, s_b_valid};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory side of one read: wait for AR, accept it, return rdata, check routing.
  task automatic serve_read(input string tag, input int exp_who,
                            input logic [31:0] exp_addr, input logic [31:0] rdata);
    int n;
    n = 0;
    while (!m_ar_valid && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, "_wait"}, 64'(n), 64'd1);
    chk({tag, "_araddr"}, 64'(m_ar_address), 64'(exp_addr));
    m_ar_ready = 1'b1;
    #1;
    chk({tag, "_arrdy"}, 64'(s_ar_ready), 64'(2'b01 << exp_who));
    cyc();
    m_ar_ready = 1'b0;
    m_r_valid  = 1'b1;
    m_r_data   = rdata;
    #1;
    chk({tag, "_rvld"}, 64'(s_r_valid), 64'(2'b01 << exp_who));
    chk({tag, "_rdata"}, 64'(s_r_data), 64'(rdata));
    cyc();
    m_r_valid = 1'b0;
    #1;
    chk({tag, "_idle"}, 64'(hs_bits()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    s_ar_valid = '0; s_aw_valid = '0; s_w_valid = '0;
    s_r_ready = 2'b11; s_b_ready = 2'b11;
    s_ar_address = '0; s_aw_address = '0; s_w_data = '0;
    m_ar_ready = 0; m_r_valid = 0; m_r_data = '0;
    m_aw_ready = 0; m_w_ready = 0; m_b_valid = 0; m_b_response = 0;

    do_reset();
    chk("reset_outputs", 64'(hs_bits()), 64'd0);

    // single read from requester 0
    s_ar_valid = 2'b01;
    s_ar_address[31:0] = 32'h0000_0040;
    #1;
    chk("t1_idle_no_ar", 64'(m_ar_valid), 64'd0);
    serve_read("t1", 0, 32'h40, 32'hDEAD_BEEF);
    s_ar_valid = 2'b00;

    // simultaneous reads after reset: req0 first, req1 after one idle cycle
    do_reset();
    s_ar_valid = 2'b11;
    s_ar_address = {32'h0000_0200, 32'h0000_0100};
    serve_read("t2_r0", 0, 32'h100, 32'h1111_0000);
    s_ar_valid = 2'b10;
    serve_read("t2_r1", 1, 32'h200, 32'h2222_0000);
    s_ar_valid = 2'b00;

    // continuous requests alternate 0,1,0,1,0,1
    s_ar_valid = 2'b11;
    s_ar_address = {32'h0000_2000, 32'h0000_1000};
    for (int i = 0; i < 6; i++) begin
      serve_read($sformatf("t3_%0d", i), i % 2,
                 (i % 2 == 0) ? 32'h1000 : 32'h2000, 32'hA000_0000 + 32'(i));
    end
    s_ar_valid = 2'b00;

    // write from req1, W accepted three cycles before AW
    s_aw_valid = 2'b10; s_w_valid = 2'b10;
    s_aw_address[63:32] = 32'h0000_0300;
    s_w_data[63:32]     = 32'h1234_5678;
    cyc();
    chk("t4_awvld", 64'(m_aw_valid), 64'd1);
    chk("t4_awaddr", 64'(m_aw_address), 64'h300);
    chk("t4_wdata", 64'(m_w_data), 64'h1234_5678);
    m_w_ready = 1'b1;
    #1;
    chk("t4_wrdy", 64'({s_aw_ready, s_w_ready}), 64'b00_10);
    cyc();
    m_w_ready = 1'b0;
    #1;
    chk("t4_w_masked", 64'({m_w_valid, m_aw_valid}), 64'b01);
    cyc();
    cyc();
    m_aw_ready = 1'b1;
    #1;
    chk("t4_awrdy", 64'(s_aw_ready), 64'b10);
    cyc();
    m_aw_ready = 1'b0;
    s_aw_valid = 2'b00; s_w_valid = 2'b00;
    m_b_valid = 1'b1; m_b_response = 1'b0;
    #1;
    chk("t4_bvld", 64'({s_b_valid, m_b_ready, s_b_response}), 64'b10_1_0);
    cyc();
    m_b_valid = 1'b0;
    #1;
    chk("t4_idle", 64'(hs_bits()), 64'd0);

    // req0 write and read together: write first, same-cycle AW/W
    s_aw_valid = 2'b01; s_w_valid = 2'b01; s_ar_valid = 2'b01;
    s_aw_address[31:0] = 32'h0000_0500;
    s_ar_address[31:0] = 32'h0000_0600;
    s_w_data[31:0]     = 32'hCAFE_F00D;
    cyc();
    chk("t5_write_first", 64'({m_ar_valid, m_aw_valid, m_w_valid}), 64'b011);
    chk("t5_awaddr", 64'(m_aw_address), 64'h500);
    m_aw_ready = 1'b1; m_w_ready = 1'b1;
    #1;
    chk("t5_both_rdy", 64'({s_aw_ready, s_w_ready}), 64'b01_01);
    cyc();
    m_aw_ready = 1'b0; m_w_ready = 1'b0;
    s_aw_valid = 2'b00; s_w_valid = 2'b00;
    m_b_valid = 1'b1; m_b_response = 1'b1;
    #1;
    chk("t5_bresp", 64'({m_ar_valid, s_b_valid, s_b_response}), 64'b0_01_1);
    cyc();
    m_b_valid = 1'b0; m_b_response = 1'b0;
    #1;
    chk("t5_gap", 64'(m_ar_valid), 64'd0);
    serve_read("t5_rd", 0, 32'h600, 32'h5555_6666);
    s_ar_valid = 2'b00;

    // reset during RD_DATA of a req0 read; last_grant must return to 1
    s_ar_valid = 2'b10;
    s_ar_address[63:32] = 32'h0000_0A00;
    serve_read("t6_pre", 1, 32'hA00, 32'h0);
    s_ar_valid = 2'b01;
    s_ar_address[31:0] = 32'h0000_0B00;
    cyc();
    m_ar_ready = 1'b1;
    #1;
    chk("t6_ar", 64'({m_ar_valid, s_ar_ready}), 64'b1_01);
    cyc();
    m_ar_ready = 1'b0;
    s_ar_valid = 2'b00;
    #1;
    chk("t6_rdata_wait", 64'({m_r_ready, s_r_valid}), 64'b1_00);
    rst = 1'b1;
    s_ar_valid = 2'b11;
    s_ar_address = {32'h0000_0D00, 32'h0000_0C00};
    cyc();
    chk("t6_rst_outputs", 64'(hs_bits()), 64'd0);
    cyc();
    rst = 1'b0;
    #1;
    serve_read("t6_post", 0, 32'hC00, 32'h7777_8888);
    s_ar_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
